// File: rtl/pixel_preproc_stream.sv
// RGB-to-intensity front-end: channel expansion, mode-selected conversion and frame tagging
// through a two-stage valid/ready pipeline.
module pixel_preproc_stream #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CH_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_sync,
  input  logic [1:0]        mode,
  input  logic [7:0]        thresh,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [3*CH_W-1:0] x_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [7:0]        y_data,
  output logic              y_sop,
  output logic              y_eop,
  output logic [1:0]        active_mode
);

  localparam int XW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] XMax = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YMax = YW'(IMG_HEIGHT - 1);

  // MSB-first replication of the channel bits, truncated to 8 bits.
  function automatic logic [7:0] expand(input logic [CH_W-1:0] c);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      e[7-i] = c[CH_W-1-(i%CH_W)];
    end
    return e;
  endfunction

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          sync_pend;
  logic [1:0]    mode_r;
  logic [7:0]    thresh_r;

  logic          s1_valid;
  logic [7:0]    s1_r, s1_g, s1_b;
  logic          s1_sop, s1_eop;
  logic [1:0]    s1_mode;
  logic [7:0]    s1_thresh;

  logic          s2_valid;
  logic [7:0]    s2_data;
  logic          s2_sop, s2_eop;

  logic          s2_load, s1_load, accept;
  logic          restart;
  logic [XW-1:0] cur_x, nxt_x;
  logic [YW-1:0] cur_y, nxt_y;
  logic          cur_sop, cur_eop;
  logic [1:0]    use_mode;
  logic [7:0]    use_thresh;

  assign s2_load = !s2_valid | y_ready;
  assign s1_load = !s1_valid | s2_load;
  assign x_ready = s1_load;
  assign accept  = x_valid & x_ready;

  // A pending or same-cycle frame_sync forces the accepted pixel to the origin.
  always_comb begin
    restart    = sync_pend | frame_sync;
    cur_x      = restart ? '0 : x_cnt;
    cur_y      = restart ? '0 : y_cnt;
    cur_sop    = (cur_x == '0) && (cur_y == '0);
    cur_eop    = (cur_x == XMax) && (cur_y == YMax);
    use_mode   = cur_sop ? mode : mode_r;
    use_thresh = cur_sop ? thresh : thresh_r;
    if (cur_x == XMax) begin
      nxt_x = '0;
      nxt_y = (cur_y == YMax) ? '0 : cur_y + 1'b1;
    end else begin
      nxt_x = cur_x + 1'b1;
      nxt_y = cur_y;
    end
  end

  logic [9:0]  sum;
  logic [15:0] luma_acc;
  logic [7:0]  luma;
  logic [7:0]  conv;

  always_comb begin
    sum      = 10'(s1_r) + 10'(s1_g) + 10'(s1_b);
    luma_acc = 16'(s1_r) * 16'd77 + 16'(s1_g) * 16'd150 + 16'(s1_b) * 16'd29;
    luma     = luma_acc[15:8];
    conv     = '0;
    unique case (s1_mode)
      2'd0: conv = 8'(sum / 10'd3);
      2'd1: conv = luma;
      2'd2: conv = s1_g;
      2'd3: conv = (luma >= s1_thresh) ? 8'hFF : 8'h00;
      default: conv = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      sync_pend <= 1'b0;
      mode_r    <= '0;
      thresh_r  <= '0;
      s1_valid  <= 1'b0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      s1_mode   <= '0;
      s1_thresh <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_sop    <= 1'b0;
      s2_eop    <= 1'b0;
    end else begin
      if (accept) begin
        x_cnt     <= nxt_x;
        y_cnt     <= nxt_y;
        sync_pend <= 1'b0;
        if (cur_sop) begin
          mode_r   <= mode;
          thresh_r <= thresh;
        end
      end else if (frame_sync) begin
        sync_pend <= 1'b1;
      end

      if (s1_load) begin
        s1_valid <= x_valid;
        if (x_valid) begin
          s1_r      <= expand(x_data[3*CH_W-1:2*CH_W]);
          s1_g      <= expand(x_data[2*CH_W-1:CH_W]);
          s1_b      <= expand(x_data[CH_W-1:0]);
          s1_sop    <= cur_sop;
          s1_eop    <= cur_eop;
          s1_mode   <= use_mode;
          s1_thresh <= use_thresh;
        end
      end

      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= conv;
          s2_sop  <= s1_sop;
          s2_eop  <= s1_eop;
        end
      end
    end
  end

  assign y_valid     = s2_valid;
  assign y_data      = s2_data;
  assign y_sop       = s2_sop;
  assign y_eop       = s2_eop;
  assign active_mode = mode_r;

endmodule

// File: tb/tb_pixel_preproc_stream.sv
// Bench for pixel_preproc_stream on a 4x3 image with RGB444 input, checked against a
// frame-position reference model and an expected-output queue.
module tb_pixel_preproc_stream;

  localparam int W = 4;
  localparam int H = 3;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_sync = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  thresh = 8'd0;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [11:0] x_data = 12'd0;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic [7:0]  y_data;
  logic        y_sop;
  logic        y_eop;
  logic [1:0]  active_mode;

  pixel_preproc_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CH_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .frame_sync(frame_sync), .mode(mode), .thresh(thresh),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_sop(y_sop), .y_eop(y_eop),
    .active_mode(active_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
    int         c;
  } exp_t;

  exp_t       q[$];
  int         passed = 0;
  int         total = 0;
  int         cyc = 0;
  int         pos = 0;
  bit         pend = 0;
  logic [1:0] m_mode = 0;
  logic [7:0] m_thr = 0;
  bit         lat_chk = 0;
  bit         just_reset = 0;
  bit         hold_pend = 0;
  logic [7:0] hold_d;
  logic       hold_s, hold_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Intensity from the conversion rules; 4-bit channels widen by x17 (0xA -> 0xAA).
  function automatic logic [7:0] ref_y(input logic [11:0] px, input logic [1:0] m,
                                       input logic [7:0] th);
    int r, g, b, luma;
    r = int'(px[11:8]) * 17;
    g = int'(px[7:4]) * 17;
    b = int'(px[3:0]) * 17;
    luma = (77 * r + 150 * g + 29 * b) / 256;
    case (m)
      2'd0: return 8'((r + g + b) / 3);
      2'd1: return 8'(luma);
      2'd2: return 8'(g);
      default: return (luma >= int'(th)) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
      pos = 0; pend = 0; m_mode = 0; m_thr = 0;
      hold_pend = 0;
      just_reset = 1;
    end else begin
      if (just_reset) begin
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_data", 32'(y_data), 32'd0);
        chk("rst_sop_eop", {30'd0, y_sop, y_eop}, 32'd0);
        just_reset = 0;
      end
      chk("active_mode", 32'(active_mode), 32'(m_mode));
      chk("x_ready", 32'(x_ready), 32'(!(q.size() == 2 && !y_ready)));
      if (hold_pend) begin
        chk("stall_valid", 32'(y_valid), 32'd1);
        chk("stall_data", {22'd0, hold_d, hold_s, hold_e}, {22'd0, y_data, y_sop, y_eop});
      end
      hold_pend = y_valid && !y_ready;
      hold_d = y_data; hold_s = y_sop; hold_e = y_eop;
      if (y_valid && y_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("y_data", 32'(y_data), 32'(e.d));
          chk("y_sop", 32'(y_sop), 32'(e.s));
          chk("y_eop", 32'(y_eop), 32'(e.e));
          if (lat_chk) chk("latency", 32'(cyc - e.c), 32'd2);
        end
      end
      if (x_valid && x_ready) begin
        if (pend || frame_sync) pos = 0;
        if (pos == 0) begin
          m_mode = mode;
          m_thr = thresh;
        end
        e.d = ref_y(x_data, m_mode, m_thr);
        e.s = (pos == 0);
        e.e = (pos == NPIX - 1);
        e.c = cyc;
        q.push_back(e);
        pos = (pos + 1) % NPIX;
        pend = 0;
      end else if (frame_sync) begin
        pend = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [11:0] d);
    x_valid = 1'b1;
    x_data = d;
    step();
  endtask

  task automatic drain();
    x_valid = 1'b0;
    y_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    // Reset and mode-0 frame with a wrap into the next frame.
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    mode = 2'd0;
    lat_chk = 1;
    px(12'hF00); px(12'h0F0); px(12'hFFF);
    for (int i = 0; i < 10; i++) px(12'($urandom));

    // Mode 1 on a resynchronised frame.
    frame_sync = 1'b1; mode = 2'd1;
    px(12'hFFF);
    frame_sync = 1'b0;
    px(12'h000);
    for (int i = 0; i < 4; i++) px(12'($urandom));

    // Mode 3 threshold around mid-grey.
    frame_sync = 1'b1; mode = 2'd3; thresh = 8'h80;
    px(12'h888);
    frame_sync = 1'b0;
    px(12'h777);
    for (int i = 0; i < 5; i++) px(12'($urandom));
    drain();
    lat_chk = 0;

    // Random backpressure, data, mode and sync pulses.
    for (int i = 0; i < 300; i++) begin
      x_valid = ($urandom_range(0, 9) < 8);
      y_ready = $urandom_range(0, 1);
      x_data = 12'($urandom);
      mode = 2'($urandom);
      thresh = 8'($urandom);
      frame_sync = ($urandom_range(0, 15) == 0);
      step();
      frame_sync = 1'b0;
    end
    drain();

    // Mode change mid-frame, then a sync pulse at x_cnt=2.
    frame_sync = 1'b1; mode = 2'd0;
    px(12'h123);
    frame_sync = 1'b0;
    mode = 2'd2;
    px(12'h456);
    chk("mode_held", 32'(active_mode), 32'd0);
    x_valid = 1'b0; frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    px(12'h9A5);
    chk("mode_new", 32'(active_mode), 32'd2);
    px(12'h3C7);
    drain();

    // Reset with both stages full and the output stalled.
    mode = 2'd1;
    y_ready = 1'b0;
    for (int i = 0; i < 6; i++) px(12'($urandom));
    chk("full_stall", 32'(x_ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    x_valid = 1'b0;
    y_ready = 1'b1;
    step();
    chk("post_rst_ready", 32'(x_ready), 32'd1);
    chk("post_rst_mode", 32'(active_mode), 32'd0);
    mode = 2'd2;
    px(12'h5A5);
    px(12'hC3C);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_preproc_stream.md
# pixel_preproc_stream

Parametrised pixel front-end for the zebra-crossing detection path. It converts packed RGB pixels of configurable channel width into an 8-bit intensity stream using a runtime-selectable mode, and tags each output pixel with start-of-frame and end-of-frame markers from internal x/y counters. It applies valid/ready backpressure through a 2-stage pipeline. It sits between the image buffer's read side and the pattern-recognition core, and generalises the fixed RGB444-average conversion into a handshaked, frame-aware block.

## Interface
- IMG_WIDTH, 640, pixels per line (≥2)
- IMG_HEIGHT, 480, lines per frame (≥2)
- CH_W, 4, bits per colour channel (1..8)
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- frame_sync  in  1  one-cycle pulse; forces the next accepted pixel to be (0,0)
- mode  in  2  0=average, 1=luma, 2=green only, 3=binary threshold; sampled only at frame start
- thresh  in  8  threshold for mode 3; sampled with mode
- x_valid  in  1  input pixel valid
- x_ready  out  1  block can accept input
- x_data  in  3*CH_W  {R,G,B}, R in the MSBs
- y_valid  out  1  output pixel valid
- y_ready  in  1  downstream accepts
- y_data  out  8  intensity
- y_sop  out  1  output pixel is (0,0); valid only with y_valid
- y_eop  out  1  output pixel is (IMG_WIDTH-1, IMG_HEIGHT-1); valid only with y_valid
- active_mode  out  2  mode in force for the current frame

## Operation
- Channel expansion: each channel widens to 8 bits by repeated MSB-first replication of its CH_W bits, truncated to 8 bits. With CH_W=4, 0xA becomes 0xAA. With CH_W=8, the channel passes unchanged.
- Mode 0: y = floor((R8+G8+B8)/3). Use a 10-bit sum.
- Mode 1: y = (77·R8 + 150·G8 + 29·B8) >> 8. Use a 16-bit accumulator. The maximum result is 255, so no saturation is needed.
- Mode 2: y = G8.
- Mode 3: y = 8'hFF if the mode-1 luma ≥ thresh_r, else 8'h00.
- Counters:
  - x_cnt and y_cnt advance only on input acceptance (x_valid & x_ready).
  - x_cnt wraps from IMG_WIDTH-1 to 0 and then increments y_cnt.
  - y_cnt wraps from IMG_HEIGHT-1 to 0.
- frame_sync:
  - Sets a pending flag.
  - The next accepted pixel is coordinate (0,0), and the counters continue from there.
  - If frame_sync and an accept occur in the same cycle, the pixel accepted in that cycle is (0,0).
- Mode latch: mode_r and thresh_r load from mode and thresh when a pixel is accepted as (0,0). That pixel uses the newly loaded values. Mode changes mid-frame have no effect until the next frame.
- Tags: sop and eop are computed at stage 1 from the coordinates and travel with the data.

## Timing
- Pipeline:
  - Stage 1 registers the expanded channels, sop/eop and the latched mode.
  - Stage 2 registers y_data.
  - Latency from input accept to y_valid is 2 cycles with y_ready held high.
  - Throughput is 1 pixel/cycle.
- Stall rules:
  - Stage 2 loads when !s2_valid | y_ready.
  - Stage 1 loads when !s1_valid | stage-2 load.
  - x_ready = !s1_valid | stage-2 load. This is combinational from y_ready; there is no skid buffer.
- While y_valid=1 and y_ready=0, y_data, y_sop and y_eop hold stable.
- Reset (rst_n=0 at a clk edge), regardless of state or in-flight data:
  - y_valid=0, y_data=0, y_sop=0, y_eop=0.
  - x_ready=1 on the first cycle after reset.
  - Counters=0, frame_sync pending=0.
  - mode_r=0 and active_mode=0, thresh_r=0.
  - In-flight pixels are discarded.
- After reset, the first accepted pixel is (0,0) and is tagged sop.
- x_valid=0 does not advance the counters. Bubbles propagate as y_valid=0.

## Test plan
- Mode 0, CH_W=4, y_ready=1, x_data=12'hF00 then 12'h0F0 → y_data=0x55 each, 2 cycles after each accept; 12'hFFF → 0xFF.
- Mode 1, pixel 12'hFFF → 0xFF; 12'h000 → 0x00. Mode 3 with thresh=0x80: 12'h888 → 0xFF, 12'h777 → 0x00.
- Small image (IMG_WIDTH=4, IMG_HEIGHT=3), 12 continuous pixels → y_sop only on output 0, y_eop only on output 11; pixel 12 carries sop again (wrap).
- y_ready toggled randomly with x_valid=1 → no pixel lost or duplicated, output order preserved, outputs stable while stalled, x_ready drops within the same cycle once both stages are full.
- mode changed 0→2 mid-frame → active_mode stays 0 until the next (0,0) accept, then becomes 2. frame_sync asserted at x_cnt=2 → the next accepted pixel is tagged sop.
- rst_n=0 for 1 cycle with both stages full and y_ready=0 → the next cycle shows y_valid=0, x_ready=1, active_mode=0, and the next accepted pixel emerges tagged sop.
